// File: rtl/sa3_pkg.sv
// Shared types and constants for the 3x3 systolic multiplier sequencer.
package sa3_pkg;

    localparam int N                 = 3;
    localparam int NUM_EL            = N * N;
    localparam int DW_DEFAULT        = 2;
    localparam int CW_DEFAULT        = 5;
    localparam int DRAIN_CYC_DEFAULT = 5;

    // Index of the final result beat (row-major, last element).
    localparam logic [3:0] LAST_IDX = 4'(NUM_EL - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        CAPTURE,
        STREAM
    } state_t;

    // Row-major flattening of a (row, col) matrix coordinate.
    function automatic logic [3:0] mat_idx(input logic [1:0] row, input logic [1:0] col);
        return ({2'b00, row} * 4'd3) + {2'b00, col};
    endfunction

endpackage

// File: rtl/sa3_res_buf.sv
// Capture buffer for the nine array accumulators plus the row-major
// valid/ready result stream that drains it.
module sa3_res_buf
    import sa3_pkg::*;
#(
    parameter int CW = CW_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 capture,
    input  logic                 stream_en,
    input  logic [9*CW-1:0]      arr_c,
    input  logic                 res_ready,
    output logic                 res_valid,
    output logic [CW-1:0]        res_data,
    output logic [3:0]           res_idx,
    output logic                 res_last,
    output logic                 stream_end,
    output logic                 done
);

    logic [CW-1:0] cap_buf [NUM_EL];

    // Snapshot all nine accumulator fields in one cycle once the array has drained.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_EL; i++) begin
                cap_buf[i] <= '0;
            end
        end else if (capture) begin
            for (int i = 0; i < NUM_EL; i++) begin
                cap_buf[i] <= arr_c[CW*i +: CW];
            end
        end
    end

    assign res_valid  = stream_en;
    assign res_last   = res_valid && (res_idx == LAST_IDX);
    assign stream_end = res_valid && res_ready && res_last;
    assign res_data   = res_valid ? cap_buf[res_idx] : '0;

    // Advance the beat index on each accepted beat; wrap to 0 and flag done after the last one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_idx <= '0;
            done    <= 1'b0;
        end else begin
            done <= stream_end;
            if (stream_end) begin
                res_idx <= '0;
            end else if (res_valid && res_ready) begin
                res_idx <= res_idx + 4'd1;
            end
        end
    end

endmodule

// File: rtl/sa3_feed_ctrl.sv
// Sequencer for the 3x3 systolic matrix multiplier: holds operands A and B,
// clears the array, feeds unskewed row/column streams, waits for the drain,
// then captures and streams the nine results.
module sa3_feed_ctrl
    import sa3_pkg::*;
#(
    parameter int DW        = DW_DEFAULT,
    parameter int CW        = CW_DEFAULT,
    parameter int DRAIN_CYC = DRAIN_CYC_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ld_valid,
    output logic               ld_ready,
    input  logic               ld_sel,
    input  logic [1:0]         ld_row,
    input  logic [1:0]         ld_col,
    input  logic [DW-1:0]      ld_data,
    output logic               ld_err,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               arr_clr,
    output logic [DW-1:0]      arr_a1,
    output logic [DW-1:0]      arr_a2,
    output logic [DW-1:0]      arr_a3,
    output logic [DW-1:0]      arr_b1,
    output logic [DW-1:0]      arr_b2,
    output logic [DW-1:0]      arr_b3,
    input  logic [9*CW-1:0]    arr_c,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [CW-1:0]      res_data,
    output logic [3:0]         res_idx,
    output logic               res_last
);

    localparam logic [2:0] LAST_DRAIN = 3'(DRAIN_CYC - 1);

    state_t        state, state_nx;
    logic [2:0]    cnt, cnt_nx;
    logic [DW-1:0] mat_a [NUM_EL];
    logic [DW-1:0] mat_b [NUM_EL];
    logic          ld_accept;
    logic          ld_in_range;
    logic          stream_end;

    assign ld_ready    = (state == IDLE);
    assign busy        = (state != IDLE);
    assign ld_accept   = ld_valid && ld_ready;
    assign ld_in_range = (ld_row != 2'd3) && (ld_col != 2'd3);

    // Operand storage: in-range accepted writes update one element, out-of-range ones raise ld_err.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_EL; i++) begin
                mat_a[i] <= '0;
                mat_b[i] <= '0;
            end
            ld_err <= 1'b0;
        end else begin
            ld_err <= ld_accept && !ld_in_range;
            if (ld_accept && ld_in_range) begin
                if (ld_sel) begin
                    mat_b[mat_idx(ld_row, ld_col)] <= ld_data;
                end else begin
                    mat_a[mat_idx(ld_row, ld_col)] <= ld_data;
                end
            end
        end
    end

    // FSM state and the shared FEED/DRAIN beat counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state logic and array drive: streams are zero outside FEED so the array only ever sees operands then zeros.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        arr_clr  = 1'b0;
        arr_a1   = '0;
        arr_a2   = '0;
        arr_a3   = '0;
        arr_b1   = '0;
        arr_b2   = '0;
        arr_b3   = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = CLEAR;
                end
            end
            CLEAR: begin
                arr_clr  = 1'b1;
                cnt_nx   = '0;
                state_nx = FEED;
            end
            FEED: begin
                arr_a1 = mat_a[mat_idx(2'd0, cnt[1:0])];
                arr_a2 = mat_a[mat_idx(2'd1, cnt[1:0])];
                arr_a3 = mat_a[mat_idx(2'd2, cnt[1:0])];
                arr_b1 = mat_b[mat_idx(cnt[1:0], 2'd0)];
                arr_b2 = mat_b[mat_idx(cnt[1:0], 2'd1)];
                arr_b3 = mat_b[mat_idx(cnt[1:0], 2'd2)];
                if (cnt == 3'd2) begin
                    cnt_nx   = '0;
                    state_nx = DRAIN;
                end else begin
                    cnt_nx = cnt + 3'd1;
                end
            end
            DRAIN: begin
                if (cnt == LAST_DRAIN) begin
                    cnt_nx   = '0;
                    state_nx = CAPTURE;
                end else begin
                    cnt_nx = cnt + 3'd1;
                end
            end
            CAPTURE: begin
                state_nx = STREAM;
            end
            STREAM: begin
                if (stream_end) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    sa3_res_buf #(
        .CW(CW)
    ) u_res_buf (
        .clk       (clk),
        .reset     (reset),
        .capture   (state == CAPTURE),
        .stream_en (state == STREAM),
        .arr_c     (arr_c),
        .res_ready (res_ready),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_idx   (res_idx),
        .res_last  (res_last),
        .stream_end(stream_end),
        .done      (done)
    );

endmodule

// File: tb/tb_sa3_feed_ctrl.sv
// Self-checking bench for sa3_feed_ctrl, with a behavioural skewed 3x3
// systolic array closing the loop from arr_a*/arr_b* back to arr_c.
module tb_sa3_feed_ctrl;
    import sa3_pkg::*;

    localparam int DW = DW_DEFAULT;
    localparam int CW = CW_DEFAULT;

    typedef struct {
        logic          sel;
        logic [1:0]    row;
        logic [1:0]    col;
        logic [DW-1:0] data;
        logic          exp_err;
    } ld_vec_t;

    logic            clk;
    logic            reset;
    logic            ld_valid;
    logic            ld_ready;
    logic            ld_sel;
    logic [1:0]      ld_row;
    logic [1:0]      ld_col;
    logic [DW-1:0]   ld_data;
    logic            ld_err;
    logic            start;
    logic            busy;
    logic            done;
    logic            arr_clr;
    logic [DW-1:0]   arr_a1, arr_a2, arr_a3;
    logic [DW-1:0]   arr_b1, arr_b2, arr_b3;
    logic [9*CW-1:0] arr_c;
    logic            res_valid;
    logic            res_ready;
    logic [CW-1:0]   res_data;
    logic [3:0]      res_idx;
    logic            res_last;

    int num_checks = 0;
    int num_errors = 0;

    int            a_ref [3][3];
    int            b_ref [3][3];
    logic [CW-1:0] exp_res [9];
    ld_vec_t       load_tab [$];

    int s1_a [3][3] = '{'{1, 2, 3}, '{0, 1, 2}, '{3, 3, 3}};
    int s1_b [3][3] = '{'{1, 0, 2}, '{2, 1, 0}, '{3, 3, 1}};
    int s1_c [9]    = '{14, 11, 5, 8, 7, 2, 18, 12, 9};

    sa3_feed_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .ld_sel   (ld_sel),
        .ld_row   (ld_row),
        .ld_col   (ld_col),
        .ld_data  (ld_data),
        .ld_err   (ld_err),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .arr_clr  (arr_clr),
        .arr_a1   (arr_a1),
        .arr_a2   (arr_a2),
        .arr_a3   (arr_a3),
        .arr_b1   (arr_b1),
        .arr_b2   (arr_b2),
        .arr_b3   (arr_b3),
        .arr_c    (arr_c),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data (res_data),
        .res_idx  (res_idx),
        .res_last (res_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural systolic array ----------------
    logic [DW-1:0] a_raw [3];
    logic [DW-1:0] b_raw [3];
    logic [DW-1:0] a_sk  [3];
    logic [DW-1:0] b_sk  [3];
    logic [DW-1:0] a_pipe [3][2];
    logic [DW-1:0] b_pipe [3][2];
    logic [DW-1:0] pe_a [3][3];
    logic [DW-1:0] pe_b [3][3];
    logic [CW-1:0] pe_acc [3][3];

    assign a_raw[0] = arr_a1;
    assign a_raw[1] = arr_a2;
    assign a_raw[2] = arr_a3;
    assign b_raw[0] = arr_b1;
    assign b_raw[1] = arr_b2;
    assign b_raw[2] = arr_b3;
    assign a_sk[0]  = a_raw[0];
    assign a_sk[1]  = a_pipe[1][0];
    assign a_sk[2]  = a_pipe[2][1];
    assign b_sk[0]  = b_raw[0];
    assign b_sk[1]  = b_pipe[1][0];
    assign b_sk[2]  = b_pipe[2][1];

    // Row i / column j enter after i / j skew flops, then hop one PE per cycle while each PE accumulates a*b.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            a_pipe[i][0] <= arr_clr ? '0 : a_raw[i];
            a_pipe[i][1] <= arr_clr ? '0 : a_pipe[i][0];
            b_pipe[i][0] <= arr_clr ? '0 : b_raw[i];
            b_pipe[i][1] <= arr_clr ? '0 : b_pipe[i][0];
        end
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                automatic int im = (i == 0) ? 0 : i - 1;
                automatic int jm = (j == 0) ? 0 : j - 1;
                automatic logic [DW-1:0] ain = (j == 0) ? a_sk[i] : pe_a[i][jm];
                automatic logic [DW-1:0] bin = (i == 0) ? b_sk[j] : pe_b[im][j];
                if (arr_clr) begin
                    pe_a[i][j]   <= '0;
                    pe_b[i][j]   <= '0;
                    pe_acc[i][j] <= '0;
                end else begin
                    pe_a[i][j]   <= ain;
                    pe_b[i][j]   <= bin;
                    pe_acc[i][j] <= pe_acc[i][j] + CW'(ain) * CW'(bin);
                end
            end
        end
    end

    // Pack the accumulators into the flat arr_c bus, element 3*row+col.
    always_comb begin
        arr_c = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                arr_c[CW*(3*i+j) +: CW] = pe_acc[i][j];
            end
        end
    end

    // ---------------- helpers ----------------
    function automatic ld_vec_t mkVec(input int sel, input int row, input int col,
                                      input int data, input int err);
        ld_vec_t v;
        v.sel     = sel[0];
        v.row     = row[1:0];
        v.col     = col[1:0];
        v.data    = data[DW-1:0];
        v.exp_err = err[0];
        return v;
    endfunction

    function automatic logic [CW-1:0] refProduct(input int r, input int c);
        int sum = 0;
        for (int k = 0; k < 3; k++) begin
            sum += a_ref[r][k] * b_ref[k][c];
        end
        return CW'(sum);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input ld_vec_t v);
        ld_valid = 1'b1;
        ld_sel   = v.sel;
        ld_row   = v.row;
        ld_col   = v.col;
        ld_data  = v.data;
        checkOutput("ld_ready_idle", ld_ready, 1);
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
        checkOutput("ld_err_pulse", ld_err, v.exp_err);
        if (!v.exp_err) begin
            if (v.sel) b_ref[v.row][v.col] = v.data;
            else       a_ref[v.row][v.col] = v.data;
        end
        @(posedge clk);
        #1;
        checkOutput("ld_err_one_cycle", ld_err, 0);
    endtask

    task automatic clearRefs();
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                a_ref[i][j] = 0;
                b_ref[i][j] = 0;
            end
        end
    endtask

    // One full multiply: start, check latency and feed, then consume the stream against exp_res.
    task automatic doRun(input bit toggle, input bit feed_write, input bit stream_start,
                         input int abort_beat, input bit with_write, input ld_vec_t wv);
        int  cyc;
        int  cnt;
        int  beat;
        bit  rdy;
        bit  start_sent;
        start = 1'b1;
        if (with_write) begin
            ld_valid = 1'b1;
            ld_sel   = wv.sel;
            ld_row   = wv.row;
            ld_col   = wv.col;
            ld_data  = wv.data;
            if (wv.sel) b_ref[wv.row][wv.col] = wv.data;
            else        a_ref[wv.row][wv.col] = wv.data;
        end
        @(posedge clk);
        #1;
        start    = 1'b0;
        ld_valid = 1'b0;
        checkOutput("busy_in_clear", busy, 1);
        checkOutput("arr_clr_in_clear", arr_clr, 1);
        checkOutput("arr_a1_in_clear", arr_a1, 0);
        cyc = 0;
        while (!res_valid && cyc < 40) begin
            if (cyc == 1) begin
                checkOutput("arr_clr_in_feed", arr_clr, 0);
                checkOutput("arr_a1_feed_k0", arr_a1, a_ref[0][0]);
                checkOutput("arr_b3_feed_k0", arr_b3, b_ref[0][2]);
                if (feed_write) begin
                    ld_valid = 1'b1;
                    ld_sel   = 1'b0;
                    ld_row   = 2'd0;
                    ld_col   = 2'd0;
                    ld_data  = 2'd0;
                    checkOutput("ld_ready_in_feed", ld_ready, 0);
                end
            end
            if (cyc == 2) begin
                ld_valid = 1'b0;
                checkOutput("arr_a3_feed_k1", arr_a3, a_ref[2][1]);
            end
            if (cyc == 3) begin
                checkOutput("arr_b2_feed_k2", arr_b2, b_ref[2][1]);
            end
            if (cyc == 5) begin
                checkOutput("arr_a3_in_drain", arr_a3, 0);
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput("first_valid_latency", cyc, 10);

        beat       = 0;
        cnt        = 0;
        start_sent = 1'b0;
        while (beat < 9 && cnt < 200) begin
            rdy       = toggle ? ((cnt % 4 == 0) || (cnt % 4 == 3)) : 1'b1;
            res_ready = rdy;
            start     = 1'b0;
            if (stream_start && beat == 3 && !start_sent) begin
                start      = 1'b1;
                start_sent = 1'b1;
            end
            checkOutput("res_valid", res_valid, 1);
            checkOutput("res_idx", res_idx, beat);
            checkOutput("res_data", res_data, exp_res[beat]);
            checkOutput("res_last", res_last, (beat == 8) ? 1 : 0);
            checkOutput("busy_streaming", busy, 1);
            checkOutput("done_early", done, 0);
            if (beat == abort_beat) begin
                #2 reset = 1'b0;
                #1;
                checkOutput("abort_ld_ready", ld_ready, 1);
                checkOutput("abort_busy", busy, 0);
                checkOutput("abort_res_valid", res_valid, 0);
                checkOutput("abort_res_idx", res_idx, 0);
                checkOutput("abort_res_data", res_data, 0);
                checkOutput("abort_res_last", res_last, 0);
                checkOutput("abort_done", done, 0);
                checkOutput("abort_arr_clr", arr_clr, 0);
                checkOutput("abort_arr_streams",
                            {arr_a1, arr_a2, arr_a3, arr_b1, arr_b2, arr_b3}, 0);
                clearRefs();
                res_ready = 1'b0;
                @(posedge clk);
                #1;
                checkOutput("abort_no_done", done, 0);
                @(negedge clk);
                reset = 1'b1;
                @(posedge clk);
                #1;
                checkOutput("abort_idle_after_release", busy, 0);
                checkOutput("abort_done_after_release", done, 0);
                return;
            end
            @(posedge clk);
            #1;
            if (rdy) beat++;
            cnt++;
        end
        start     = 1'b0;
        res_ready = 1'b0;
        checkOutput("stream_beats", beat, 9);
        checkOutput("done_pulse", done, 1);
        checkOutput("res_valid_after_last", res_valid, 0);
        checkOutput("res_idx_after_last", res_idx, 0);
        checkOutput("busy_after_last", busy, 0);
        @(posedge clk);
        #1;
        checkOutput("done_one_cycle", done, 0);
        checkOutput("no_queued_start", busy, 0);
    endtask

    // Absolute time bound so a stuck design still ends with a failure line.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // ---------------- test sequence ----------------
    initial begin
        ld_vec_t none;
        none      = mkVec(0, 0, 0, 0, 0);
        reset     = 1'b0;
        ld_valid  = 1'b0;
        ld_sel    = 1'b0;
        ld_row    = 2'd0;
        ld_col    = 2'd0;
        ld_data   = '0;
        start     = 1'b0;
        res_ready = 1'b0;

        // Scenario 1 operands, then out-of-range writes that must not land anywhere.
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                load_tab.push_back(mkVec(0, i, j, s1_a[i][j], 0));
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                load_tab.push_back(mkVec(1, i, j, s1_b[i][j], 0));
        load_tab.push_back(mkVec(0, 3, 1, 3, 1));
        load_tab.push_back(mkVec(0, 0, 3, 3, 1));
        load_tab.push_back(mkVec(1, 1, 3, 0, 1));
        load_tab.push_back(mkVec(1, 3, 3, 2, 1));

        #1;
        checkOutput("reset_ld_ready", ld_ready, 1);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_ld_err", ld_err, 0);
        checkOutput("reset_arr_clr", arr_clr, 0);
        checkOutput("reset_res_valid", res_valid, 0);
        checkOutput("reset_res_idx", res_idx, 0);
        checkOutput("reset_res_data", res_data, 0);
        checkOutput("reset_res_last", res_last, 0);
        checkOutput("reset_arr_streams", {arr_a1, arr_a2, arr_a3, arr_b1, arr_b2, arr_b3}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] scenario 1/4: load table, reference run, write during FEED");
        for (int k = 0; k < load_tab.size(); k++) applyStimulus(load_tab[k]);
        for (int k = 0; k < 9; k++) exp_res[k] = CW'(s1_c[k]);
        doRun(1'b0, 1'b1, 1'b0, -1, 1'b0, none);

        $display("[TB] scenario 3/4: ready toggling 1,0,0,1 and start during STREAM");
        doRun(1'b1, 1'b0, 1'b1, -1, 1'b0, none);

        $display("[TB] scenario 5: all-zero A right after a scenario 1 run");
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                if (!(i == 2 && j == 2)) applyStimulus(mkVec(0, i, j, 0, 0));
        for (int k = 0; k < 9; k++) exp_res[k] = '0;
        doRun(1'b0, 1'b0, 1'b0, -1, 1'b1, mkVec(0, 2, 2, 0, 0));

        $display("[TB] scenario 2: all-3 operands, maximum accumulation");
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                applyStimulus(mkVec(0, i, j, 3, 0));
                applyStimulus(mkVec(1, i, j, 3, 0));
            end
        for (int k = 0; k < 9; k++) exp_res[k] = refProduct(k / 3, k % 3);
        checkOutput("model_max_value", exp_res[8], 27);
        doRun(1'b0, 1'b0, 1'b0, -1, 1'b0, none);

        $display("[TB] scenario 6: reset at STREAM beat 4, then reload and rerun");
        doRun(1'b0, 1'b0, 1'b0, 4, 1'b0, none);
        for (int k = 0; k < 18; k++) applyStimulus(load_tab[k]);
        for (int k = 0; k < 9; k++) exp_res[k] = CW'(s1_c[k]);
        doRun(1'b0, 1'b0, 1'b0, -1, 1'b0, none);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
